// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
//   Shared types and helpers for the vending front-end blocks.
//   - N_KEYS / KEY_CODE_W : number of item-select keys and width of an item code
//   - key_code_t          : item code 0..8 (9..15 never produced)
//   - key_vec_t           : one bit per key, 1 = pressed
//   - kp_state_t          : keypad encoder press-tracking FSM state
//   - is_single_key       : true when exactly one bit of a key vector is set
//   - key_index           : index of the highest set bit (meaningful for one-hot)
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int N_KEYS     = 9;
    localparam int KEY_CODE_W = 4;

    typedef logic [KEY_CODE_W-1:0] key_code_t;
    typedef logic [N_KEYS-1:0]     key_vec_t;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_HELD    = 2'd1,
        KP_BLOCKED = 2'd2
    } kp_state_t;

    // v & (v-1) clears the lowest set bit; zero result with v != 0 means one-hot.
    function automatic logic is_single_key(input key_vec_t v);
        return (v != '0) && ((v & (v - key_vec_t'(1))) == '0);
    endfunction

    function automatic key_code_t key_index(input key_vec_t v);
        key_code_t idx;
        idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) begin
                idx = key_code_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
//   Synchronous first-word-fall-through FIFO of item codes.
//   A write into an empty FIFO becomes visible on head the cycle after the
//   write edge (no same-cycle bypass).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count cleared)
//   push       : write request; accepted when not full, or when full and a pop
//                happens on the same edge
//   push_data  : code to write
//   pop        : read request; ignored while empty
//   head       : oldest stored code (undefined content while empty)
//   full/empty : occupancy flags
//   count      : number of stored codes, 0..DEPTH
// -----------------------------------------------------------------------------
module code_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  key_code_t                push_data,
    input  logic                     pop,
    output key_code_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    key_code_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//   Turns 9 raw item-select button lines into 4-bit item codes (0..8).
//   Keys are synchronised (2 flops), debounced, and a press-tracking FSM
//   accepts only clean single-key presses: exactly one code push or one
//   multi_err pulse per press-to-release episode. Codes queue in code_fifo.
//
//   Output handshake: code_o/code_valid present the FIFO head; a code is
//   consumed on every rising edge where code_valid && code_ready. code_ready
//   is ignored while code_valid is low, and code_o reads 0 when empty.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_raw     : asynchronous button levels, bit i = item i, 1 = pressed
//   code_o      : FIFO head item code, 0 when FIFO empty
//   code_valid  : FIFO not empty
//   code_ready  : consumer accepts code_o
//   multi_err   : 1-cycle pulse, stable press with more than one key down
//   overflow    : 1-cycle pulse, accepted press dropped because FIFO full
//   state_dbg   : current press-tracking FSM state
//   level_dbg   : current FIFO occupancy
// -----------------------------------------------------------------------------
module keypad_encoder
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_KEYS-1:0]             key_raw,
    output logic [KEY_CODE_W-1:0]         code_o,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic                          multi_err,
    output logic                          overflow,
    output kp_state_t                     state_dbg,
    output logic [$clog2(FIFO_DEPTH):0]   level_dbg
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    key_vec_t         s1;
    key_vec_t         s2;
    key_vec_t         cand;
    key_vec_t         stable;
    logic [CNT_W-1:0] cnt;

    kp_state_t        state;
    kp_state_t        state_next;
    logic             push;
    logic             pop;
    key_code_t        push_code;
    key_code_t        fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    // Synchroniser and debouncer. A new candidate restarts the count; once the
    // candidate has been seen DEBOUNCE_CYCLES times in a row it becomes stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the IDLE state reacts to a new press, so any later change of the
    // stable vector before full release produces neither a push nor an error.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        multi_err  = 1'b0;
        push_code  = key_index(stable);
        case (state)
            KP_IDLE: begin
                if (stable != '0) begin
                    if (is_single_key(stable)) begin
                        push       = 1'b1;
                        state_next = KP_HELD;
                    end else begin
                        multi_err  = 1'b1;
                        state_next = KP_BLOCKED;
                    end
                end
            end
            KP_HELD, KP_BLOCKED: begin
                if (stable == '0) begin
                    state_next = KP_IDLE;
                end
            end
            default: state_next = KP_IDLE;
        endcase
    end

    assign code_valid = !fifo_empty;
    assign pop        = code_valid && code_ready;
    assign code_o     = fifo_empty ? '0 : fifo_head;
    // A same-edge pop makes room, so only an unserved full FIFO drops the code.
    assign overflow   = push && fifo_full && !pop;
    assign state_dbg  = state;

    code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (level_dbg)
    );

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;
  import vend_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [8:0] key_raw;
  logic [3:0] code_o;
  logic       code_valid;
  logic       code_ready;
  logic       multi_err;
  logic       overflow;
  kp_state_t  state_dbg;
  logic [2:0] level_dbg;

  keypad_encoder #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .code_o     (code_o),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .multi_err  (multi_err),
    .overflow   (overflow),
    .state_dbg  (state_dbg),
    .level_dbg  (level_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int multi_seen = 0;
  int ovf_seen   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [8:0] key;
    logic       rdy;
    int         n;
    int         v;
    int         code;
    int         lvl;
    int         m;
    int         o;
    kp_state_t  st;
    int         push_code;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse counters and popped-code scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (multi_err) multi_seen++;
    if (overflow) ovf_seen++;
    if (rst_n && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", int'(code_o), 99);
      end else begin
        chk("pop_code", int'(code_o), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add(input logic [8:0] key, input logic rdy, input int n,
                     input int v, input int code, input int lvl,
                     input int m, input int o, input kp_state_t st,
                     input int push_code);
    vec_t r;
    r.key = key; r.rdy = rdy; r.n = n; r.v = v; r.code = code; r.lvl = lvl;
    r.m = m; r.o = o; r.st = st; r.push_code = push_code;
    tbl.push_back(r);
  endtask

  task automatic apply(input int idx, input vec_t r);
    key_raw    = r.key;
    code_ready = r.rdy;
    multi_seen = 0;
    ovf_seen   = 0;
    if (r.push_code >= 0) exp_q.push_back(4'(r.push_code));
    repeat (r.n) @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), int'(code_valid), r.v);
    chk($sformatf("v%0d_code", idx), int'(code_o), r.code);
    chk($sformatf("v%0d_level", idx), int'(level_dbg), r.lvl);
    chk($sformatf("v%0d_multi", idx), multi_seen, r.m);
    chk($sformatf("v%0d_ovf", idx), ovf_seen, r.o);
    chk($sformatf("v%0d_state", idx), int'(state_dbg), int'(r.st));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, int'(code_valid), 0);
    chk({tag, "_code"}, int'(code_o), 0);
    chk({tag, "_multi"}, int'(multi_err), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_level"}, int'(level_dbg), 0);
    chk({tag, "_state"}, int'(state_dbg), int'(KP_IDLE));
  endtask

  // ---------------- test ----------------
  initial begin : main
    int edges;

    // Press latency: 7 edges IDLE, then push on the 8th edge after applying.
    // Release latency: state back to IDLE on the 8th edge.
    // 1: key 4 held 20 cycles, one entry only, release -> IDLE
    add(9'h010, 1'b0, 7,  0, 0, 0, 0, 0, KP_IDLE, 4);
    add(9'h010, 1'b0, 1,  1, 4, 1, 0, 0, KP_HELD, -1);
    add(9'h010, 1'b0, 12, 1, 4, 1, 0, 0, KP_HELD, -1);
    add(9'h000, 1'b0, 8,  1, 4, 1, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  0, 0, 0, 0, 0, KP_IDLE, -1);
    // 2: short glitch on key 0, then clean key 8
    add(9'h001, 1'b1, 3,  0, 0, 0, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 10, 0, 0, 0, 0, 0, KP_IDLE, -1);
    add(9'h100, 1'b0, 8,  1, 8, 1, 0, 0, KP_HELD, 8);
    add(9'h000, 1'b0, 8,  1, 8, 1, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  0, 0, 0, 0, 0, KP_IDLE, -1);
    // 3: two keys -> one multi_err, then key 2
    add(9'h00C, 1'b0, 8,  0, 0, 0, 1, 0, KP_BLOCKED, -1);
    add(9'h00C, 1'b0, 10, 0, 0, 0, 0, 0, KP_BLOCKED, -1);
    add(9'h000, 1'b0, 8,  0, 0, 0, 0, 0, KP_IDLE, -1);
    add(9'h004, 1'b0, 8,  1, 2, 1, 0, 0, KP_HELD, 2);
    add(9'h000, 1'b0, 8,  1, 2, 1, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  0, 0, 0, 0, 0, KP_IDLE, -1);
    // 4: fill with 1..4, key 5 overflows, then drain in order
    for (int k = 1; k <= 4; k++) begin
      add(9'(1 << k), 1'b0, 8, 1, 1, k, 0, 0, KP_HELD, k);
      add(9'h000,     1'b0, 8, 1, 1, k, 0, 0, KP_IDLE, -1);
    end
    add(9'h020, 1'b0, 8,  1, 1, 4, 0, 1, KP_HELD, -1);
    add(9'h000, 1'b0, 8,  1, 1, 4, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 2, 3, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 3, 2, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 4, 1, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  0, 0, 0, 0, 0, KP_IDLE, -1);
    // 5: full FIFO, pop on the push edge of key 6
    for (int k = 1; k <= 4; k++) begin
      add(9'(1 << k), 1'b0, 8, 1, 1, k, 0, 0, KP_HELD, k);
      add(9'h000,     1'b0, 8, 1, 1, k, 0, 0, KP_IDLE, -1);
    end
    add(9'h040, 1'b0, 7,  1, 1, 4, 0, 0, KP_IDLE, 6);
    add(9'h040, 1'b1, 1,  1, 2, 4, 0, 0, KP_HELD, -1);
    add(9'h040, 1'b0, 5,  1, 2, 4, 0, 0, KP_HELD, -1);
    add(9'h000, 1'b0, 8,  1, 2, 4, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 3, 3, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 4, 2, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  1, 6, 1, 0, 0, KP_IDLE, -1);
    add(9'h000, 1'b1, 1,  0, 0, 0, 0, 0, KP_IDLE, -1);
    // 6 (setup): buffer two codes before the reset sequence
    add(9'h002, 1'b0, 8,  1, 1, 1, 0, 0, KP_HELD, 1);
    add(9'h000, 1'b0, 8,  1, 1, 1, 0, 0, KP_IDLE, -1);
    add(9'h004, 1'b0, 8,  1, 1, 2, 0, 0, KP_HELD, 2);
    add(9'h000, 1'b0, 8,  1, 1, 2, 0, 0, KP_IDLE, -1);

    // reset state
    rst_n      = 1'b0;
    key_raw    = '0;
    code_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) apply(i, tbl[i]);

    // 6: key 7 held through a 1-cycle reset pulse mid-debounce
    key_raw = 9'h080;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(4'd7);
    @(posedge clk);  // first sampling edge after release
    #1;
    edges = 0;
    while (!code_valid && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("rst_latency", edges, 7);
    chk("rst_code", int'(code_o), 7);
    chk("rst_level", int'(level_dbg), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_once_level", int'(level_dbg), 1);
    chk("rst_once_state", int'(state_dbg), int'(KP_HELD));
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drain_valid", int'(code_valid), 0);
    code_ready = 1'b0;
    key_raw    = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_release_state", int'(state_dbg), int'(KP_IDLE));
    chk("exp_q_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
